// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier for 8x8 signed operands.
// It retires one Booth digit per cycle and uses valid/ready handshakes on operands and result.
module booth_seq_mult #(
    parameter int unsigned EARLY_TERM = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  mcand_q;
    logic [8:0]  bx_q;
    logic [15:0] acc_q;
    logic [1:0]  step_q;
    logic [15:0] prod_q;
    logic        outValid_q;

    logic [2:0]  triplet;
    logic [15:0] mcandExt;
    logic [15:0] partial;
    logic [15:0] shifted;
    logic [15:0] acc_d;
    logic        restZero;
    logic        lastStep;

    assign mcandExt = {{8{mcand_q[7]}}, mcand_q};

    always_comb begin
        triplet = 3'b000;
        case (step_q)
            2'd0:    triplet = bx_q[2:0];
            2'd1:    triplet = bx_q[4:2];
            2'd2:    triplet = bx_q[6:4];
            default: triplet = bx_q[8:6];
        endcase
    end

    always_comb begin
        partial = 16'h0000;
        case (triplet)
            3'b001, 3'b010: partial = mcandExt;
            3'b011:         partial = mcandExt << 1;
            3'b100:         partial = -(mcandExt << 1);
            3'b101, 3'b110: partial = -mcandExt;
            default:        partial = 16'h0000;
        endcase
    end

    assign shifted = partial << {step_q, 1'b0};
    assign acc_d   = acc_q + shifted;

    // Triplets overlap by one bit, so every higher digit is zero exactly when
    // all multiplier bits above the current triplet are equal.
    always_comb begin
        restZero = 1'b0;
        case (step_q)
            2'd0:    restZero = (&bx_q[8:2]) | ~(|bx_q[8:2]);
            2'd1:    restZero = (&bx_q[8:4]) | ~(|bx_q[8:4]);
            2'd2:    restZero = (&bx_q[8:6]) | ~(|bx_q[8:6]);
            default: restZero = 1'b1;
        endcase
    end

    assign lastStep = (step_q == 2'd3) || ((EARLY_TERM != 0) && restZero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= 8'h00;
            bx_q       <= 9'h000;
            acc_q      <= 16'h0000;
            step_q     <= 2'd0;
            prod_q     <= 16'h0000;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= a;
                        bx_q    <= {b, 1'b0};
                        acc_q   <= 16'h0000;
                        step_q  <= 2'd0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (lastStep) begin
                        prod_q     <= acc_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign prod      = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: one instance per EARLY_TERM setting, with a shared reset.
// A scoreboard queue per instance holds the reference products of accepted operand pairs.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid[2];
    logic        inReady[2];
    logic [7:0]  opA[2];
    logic [7:0]  opB[2];
    logic        outValid[2];
    logic        outReady[2];
    logic [15:0] prodW[2];
    logic        busyW[2];

    logic [15:0] expQ0[$];
    logic [15:0] expQ1[$];
    int          acceptCount[2];
    int          resultCount[2];
    bit          driverDone[2];
    int          checkCount = 0;
    int          passCount  = 0;

    localparam int RAND_PAIRS = 5000;

    booth_seq_mult #(.EARLY_TERM(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(opA[0]), .b(opB[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .prod(prodW[0]), .busy(busyW[0])
    );

    booth_seq_mult #(.EARLY_TERM(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(opA[1]), .b(opB[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .prod(prodW[1]), .busy(busyW[1])
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] refProd(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] xs;
        logic signed [15:0] ys;
        logic signed [15:0] p;
        xs = {{8{x[7]}}, x};
        ys = {{8{y[7]}}, y};
        p  = xs * ys;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    // Handshakes are sampled on the falling edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        logic [15:0] expVal;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (inValid[i] && inReady[i]) begin
                    if (i == 0) expQ0.push_back(refProd(opA[0], opB[0]));
                    else        expQ1.push_back(refProd(opA[1], opB[1]));
                    acceptCount[i]++;
                end
                if (outValid[i] && outReady[i]) begin
                    resultCount[i]++;
                    if (i == 0) begin
                        if (expQ0.size() == 0) checkOutput("sb0Extra", 1, 0);
                        else begin
                            expVal = expQ0.pop_front();
                            checkOutput("sb0Prod", prodW[0], expVal);
                        end
                    end else begin
                        if (expQ1.size() == 0) checkOutput("sb1Extra", 1, 0);
                        else begin
                            expVal = expQ1.pop_front();
                            checkOutput("sb1Prod", prodW[1], expVal);
                        end
                    end
                end
            end
        end
    end

    task automatic acceptOnly(input int idx, input logic [7:0] av, input logic [7:0] bv, output bit ok);
        int guard;
        guard = 0;
        opA[idx] = av;
        opB[idx] = bv;
        inValid[idx] = 1'b1;
        @(negedge clk);
        while (!inReady[idx] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = inReady[idx];
        @(posedge clk);
        #1;
        inValid[idx] = 1'b0;
        opA[idx] = 8'($urandom);
        opB[idx] = 8'($urandom);
        if (!ok) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] av, input logic [7:0] bv, output int latency);
        bit ok;
        acceptOnly(idx, av, bv, ok);
        latency = 0;
        while (!outValid[idx] && latency < 50) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic randomDriver(input int idx, input int n);
        logic [7:0] corner[4];
        logic [7:0] av;
        logic [7:0] bv;
        bit ok;
        corner = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            av = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            acceptOnly(idx, av, bv, ok);
        end
        driverDone[idx] = 1'b1;
    endtask

    task automatic randomReady(input int idx);
        while (!driverDone[idx]) begin
            outReady[idx] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        outReady[idx] = 1'b1;
    endtask

    initial begin
        int lat;
        int seenValid;
        int guard;
        bit ok;
        logic [7:0]  tA[3];
        logic [7:0]  tB[3];
        logic [15:0] tP[3];
        tA = '{8'h80, 8'h7F, 8'h00};
        tB = '{8'h80, 8'h80, 8'hFF};
        tP = '{16'h4000, 16'hC080, 16'h0000};

        for (int i = 0; i < 2; i++) begin
            inValid[i] = 1'b0;
            outReady[i] = 1'b1;
            opA[i] = 8'h00;
            opB[i] = 8'h00;
            acceptCount[i] = 0;
            resultCount[i] = 0;
            driverDone[i] = 1'b0;
        end
        rst = 1'b1;

        @(posedge clk);
        #1;
        checkOutput("rstInReady", inReady[0], 0);
        checkOutput("rstOutValid", outValid[0], 0);
        checkOutput("rstProd", prodW[0], 16'h0000);
        checkOutput("rstBusy", {busyW[1], busyW[0]}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("firstInReady", {inReady[1], inReady[0]}, 2'b11);
        @(posedge clk);
        #1;

        applyStimulus(0, 8'd7, 8'hFD, lat);
        checkOutput("t7x3Latency", lat, 4);
        checkOutput("t7x3Prod", prodW[0], 16'hFFEB);
        checkOutput("t7x3Busy", busyW[0], 1);
        @(posedge clk);
        #1;
        checkOutput("t7x3Idle", {inReady[0], busyW[0], outValid[0]}, 3'b100);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, tA[i], tB[i], lat);
            checkOutput("tblLatency", lat, 4);
            checkOutput("tblProd", prodW[0], tP[i]);
            @(posedge clk);
            #1;
        end

        outReady[0] = 1'b0;
        applyStimulus(0, 8'd5, 8'd6, lat);
        checkOutput("holdLatency", lat, 4);
        opA[0] = 8'd9;
        opB[0] = 8'd9;
        inValid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("holdProd", prodW[0], 16'h001E);
            checkOutput("holdValid", outValid[0], 1);
            checkOutput("holdInReady", inReady[0], 0);
        end
        inValid[0] = 1'b0;
        outReady[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("holdRelease", {inReady[0], outValid[0]}, 2'b10);
        checkOutput("holdKeepProd", prodW[0], 16'h001E);

        applyStimulus(1, 8'hF7, 8'h01, lat);
        checkOutput("etShortLatency", lat, 1);
        checkOutput("etShortProd", prodW[1], 16'hFFF7);
        @(posedge clk);
        #1;
        applyStimulus(1, 8'hF7, 8'h40, lat);
        checkOutput("etLongLatency", lat, 4);
        checkOutput("etLongProd", prodW[1], 16'hFDC0);
        @(posedge clk);
        #1;

        acceptOnly(0, 8'd100, 8'hB3, ok);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midCalcBusy", busyW[0], 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstOut", {inReady[0], busyW[0], outValid[0]}, 3'b000);
        checkOutput("asyncRstProd", prodW[0], 16'h0000);
        acceptCount[0] -= expQ0.size();
        expQ0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postRstReady", inReady[0], 1);
        seenValid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (outValid[0]) seenValid++;
        end
        checkOutput("postRstNoValid", seenValid, 0);
        applyStimulus(0, 8'd3, 8'd3, lat);
        checkOutput("postRstLatency", lat, 4);
        checkOutput("postRstProd", prodW[0], 16'h0009);
        @(posedge clk);
        #1;

        fork
            randomDriver(0, RAND_PAIRS);
            randomDriver(1, RAND_PAIRS);
            randomReady(0);
            randomReady(1);
        join

        guard = 0;
        while ((expQ0.size() != 0 || expQ1.size() != 0) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("drainQ0", expQ0.size(), 0);
        checkOutput("drainQ1", expQ1.size(), 0);
        checkOutput("oneResultPerAccept0", resultCount[0], acceptCount[0]);
        checkOutput("oneResultPerAccept1", resultCount[1], acceptCount[1]);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter EARLY_TERM, default 0; when 1, the block skips remaining Booth steps once all remaining digits are zero.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, 8 bits: signed multiplicand, two's complement.
REQ-007 SHALL have port b, input, 8 bits: signed multiplier, two's complement.
REQ-008 SHALL have port out_valid, output, 1 bit: prod holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-010 SHALL have port prod, output, 16 bits: signed product a*b.
REQ-011 SHALL have port busy, output, 1 bit: high in CALC or DONE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE with rst low; in all other cases in_ready=0.
REQ-014 SHALL accept operands on an edge with in_valid&in_ready: register a, register {b,1'b0}, clear accumulator, clear step counter (2 bits), go to CALC.
REQ-015 SHALL ignore a and b changes after acceptance; results depend only on the captured values.
REQ-016 SHALL in CALC step i (0..3) form triplet {bx[2i+2],bx[2i+1],bx[2i]} from the captured bx={b,0}.
REQ-017 SHALL map the triplet to a digit: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
REQ-018 SHALL add digit*a, sign-extended to 16 bits and shifted left 2i, into the 16-bit accumulator each CALC cycle, using two's-complement wrap.
REQ-019 SHALL, with EARLY_TERM=0, spend exactly 4 CALC cycles and enter DONE on the edge completing step 3.
REQ-020 SHALL, with EARLY_TERM=1, enter DONE on the edge completing step i when all triplets j>i decode to digit 0; the result SHALL equal the full computation.
REQ-021 SHALL load prod from the final accumulator sum on the DONE entry edge and assert out_valid from that edge; latency from accept edge to out_valid is 4 cycles when EARLY_TERM=0.
REQ-022 SHALL hold prod and out_valid stable in DONE while out_ready=0.
REQ-023 SHALL return to IDLE and deassert out_valid on an edge with out_valid&out_ready; prod keeps its last value.
REQ-024 SHALL ignore in_valid outside IDLE (no queuing) and ignore out_ready outside DONE.
REQ-025 SHALL produce exact results for all 65536 operand pairs, including -128*-128 = +16384.

Reset
REQ-026 SHALL on rst high, regardless of clk and state, force: state IDLE, prod=16'h0000, out_valid=0, busy=0, accumulator=0, counter=0, in_ready=0.
REQ-027 SHALL drive in_ready=1 from the first cycle rst is low.
REQ-028 SHALL discard any partial computation when reset arrives mid-CALC or in DONE; no out_valid pulse follows reset.

Verification
REQ-029 SHALL verify: a=7, b=-3, out_ready=1, EARLY_TERM=0 -> out_valid rises exactly 4 cycles after accept, prod=16'hFFEB, IDLE on the next edge.
REQ-030 SHALL verify: a=-128, b=-128 -> prod=16'h4000; a=127, b=-128 -> prod=16'hC080; a=0, b=-1 -> prod=16'h0000.
REQ-031 SHALL verify: a=5, b=6, out_ready=0 for 10 cycles -> prod=16'h001E and out_valid held constant, in_ready=0 and in_valid ignored throughout; then out_ready=1 -> IDLE after one edge.
REQ-032 SHALL verify: EARLY_TERM=1, a=-9, b=1 -> DONE after 1 CALC cycle, prod=16'hFFF7; b=64 (triplet3=010) -> 4 CALC cycles, a=-9 gives prod=16'hFDC0.
REQ-033 SHALL verify: rst asserted asynchronously during CALC step 2 -> outputs reach reset values immediately, no out_valid; the next operation a=3, b=3 returns prod=16'h0009.
REQ-034 SHALL verify with a random regression of at least 10000 pairs, random in_valid/out_ready, both EARLY_TERM values -> every prod equals the signed reference product, and there is one result per accept.
